twiddle_sequencer: RTL

TWIDDLE_SEQUENCER -- requirements
Module: twiddle_sequencer

---
 rtl/twiddle_pkg.sv | 52 +++++
 rtl/twiddle_rom.sv | 27 ++
 rtl/twiddle_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/twiddle_pkg.sv
// Shared types, constants and elaboration helpers for the twiddle sequencer.
// Holds the FSM state enum, the Q8 scale (256 = 1.0) and the table math.
package twiddle_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } tw_state_e;

    localparam int  Q8_SCALE = 256;
    localparam real TWO_PI   = 6.283185307179586;

    // Pointer/butterfly field width for a given log2(N_MAX).
    function automatic int ptr_width(input int log2_nmax);
        return log2_nmax - 1;
    endfunction

    // Round half away from zero.
    function automatic int q8_round(input real x);
        if (x >= 0.0)
            return $rtoi(x + 0.5);
        else
            return -$rtoi(0.5 - x);
    endfunction

    // Taylor series; the table only needs angles in [0, pi).
    function automatic real tw_cos(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int k = 1; k <= 24; k++) begin
            term = -term * x * x / (real'(2 * k - 1) * real'(2 * k));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real tw_sin(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int k = 1; k <= 24; k++) begin
            term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational N_MAX/2-entry twiddle ROM, one packed {re, im} word per entry.
// Ports: addr (table index) -> re = cos, im = -sin, both signed Q8.
module twiddle_rom
    import twiddle_pkg::*;
#(
    parameter int N_MAX = 64,
    parameter int TW_W  = 16
) (
    input  logic [ptr_width($clog2(N_MAX))-1:0] addr,
    output logic signed [TW_W-1:0]              re,
    output logic signed [TW_W-1:0]              im
);

    localparam int DEPTH = N_MAX / 2;

    logic [2*TW_W-1:0] rom_w [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam real ANG = TWO_PI * real'(i) / real'(N_MAX);
        localparam int  RE  = q8_round(real'(Q8_SCALE) * tw_cos(ANG));
        localparam int  IM  = -q8_round(real'(Q8_SCALE) * tw_sin(ANG));
        assign rom_w[i] = {TW_W'(RE), TW_W'(IM)};
    end

    assign {re, im} = rom_w[addr];

endmodule

// File: rtl/twiddle_sequencer.sv
// FFT twiddle pointer sequencer: walks stage/butterfly, emits ROM twiddles
// over a valid/ready handshake. Optional TWIDDLE_DIF_EN adds mode_dif.
// Ports: start/log2n/inverse(/mode_dif) launch a run, abort cancels it,
// out_ready accepts tw_*; busy = RUN, done and cfg_err are 1-cycle pulses.
module twiddle_sequencer
    import twiddle_pkg::*;
#(
    parameter int N_MAX     = 64,
    parameter int TW_W      = 16,
    parameter int LOG2_NMAX = $clog2(N_MAX)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [$clog2(LOG2_NMAX+1)-1:0]   log2n,
    input  logic                             inverse,
`ifdef TWIDDLE_DIF_EN
    input  logic                             mode_dif,
`endif
    input  logic                             abort,
    input  logic                             out_ready,
    output logic                             tw_valid,
    output logic [$clog2(LOG2_NMAX)-1:0]     tw_stage,
    output logic [ptr_width(LOG2_NMAX)-1:0]  tw_bfly,
    output logic [ptr_width(LOG2_NMAX)-1:0]  tw_ptr,
    output logic signed [TW_W-1:0]           tw_real,
    output logic signed [TW_W-1:0]           tw_imag,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err
);

    localparam int LW = $clog2(LOG2_NMAX + 1);
    localparam int SW = $clog2(LOG2_NMAX);
    localparam int PW = ptr_width(LOG2_NMAX);

    tw_state_e state_q;
    tw_state_e state_d;

    logic [SW-1:0] stage_q;
    logic [PW-1:0] bfly_q;
    logic [LW-1:0] log2n_q;
    logic          inv_q;
    logic          dif_q;
    logic          cfg_err_q;

    logic          cfg_ok;
    logic          launch;
    logic          accept;
    logic [PW-1:0] bfly_last;
    logic          last_b;
    logic          last_el;
    logic [PW-1:0] ptr_c;

    logic signed [TW_W-1:0] rom_re;
    logic signed [TW_W-1:0] rom_im;

    int s_i;
    int l_i;
    int keep;
    int shl;

    assign cfg_ok = (log2n != '0) && (int'(log2n) <= LOG2_NMAX);
    assign launch = (state_q == S_IDLE) && start && cfg_ok;
    assign accept = (state_q == S_RUN) && out_ready;

    // Butterflies per stage minus one: 2^(log2n-1) - 1.
    assign bfly_last = {PW{1'b1}} >> (LOG2_NMAX - int'(log2n_q));
    assign last_b    = (bfly_q == bfly_last);
    assign last_el   = last_b && (int'(stage_q) == int'(log2n_q) - 1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (launch) state_d = S_RUN;
            S_RUN: begin
                if (abort)
                    state_d = S_IDLE;
                else if (accept && last_el)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            stage_q   <= '0;
            bfly_q    <= '0;
            log2n_q   <= '0;
            inv_q     <= 1'b0;
            dif_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= (state_q == S_IDLE) && start && !cfg_ok;
            if (launch) begin
                stage_q <= '0;
                bfly_q  <= '0;
                log2n_q <= log2n;
                inv_q   <= inverse;
`ifdef TWIDDLE_DIF_EN
                dif_q   <= mode_dif;
`else
                dif_q   <= 1'b0;
`endif
            end else if (accept && !abort) begin
                if (last_b) begin
                    bfly_q <= '0;
                    if (!last_el)
                        stage_q <= stage_q + SW'(1);
                end else begin
                    bfly_q <= bfly_q + PW'(1);
                end
            end
        end
    end

    // DIT keeps b mod 2^s, scaled by 2^(N_MAX exponent-1-s).
    // DIF keeps b mod 2^(log2n-1-s), scaled by 2^(s+N_MAX exp-log2n).
    always_comb begin
        s_i  = int'(stage_q);
        l_i  = int'(log2n_q);
        keep = s_i;
        shl  = PW - s_i;
        if (dif_q) begin
            keep = l_i - 1 - s_i;
            shl  = s_i + LOG2_NMAX - l_i;
        end
        if (keep < 0) keep = 0;
        if (shl < 0)  shl  = 0;
        ptr_c = PW'((int'(bfly_q) & ((1 << keep) - 1)) << shl);
    end

    twiddle_rom #(
        .N_MAX (N_MAX),
        .TW_W  (TW_W)
    ) u_rom (
        .addr (ptr_c),
        .re   (rom_re),
        .im   (rom_im)
    );

    assign tw_valid = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign cfg_err  = cfg_err_q;
    assign tw_stage = stage_q;
    assign tw_bfly  = bfly_q;
    assign tw_ptr   = ptr_c;
    assign tw_real  = tw_valid ? rom_re : '0;
    assign tw_imag  = !tw_valid ? '0 : (inv_q ? -rom_im : rom_im);

endmodule
